// File: rtl/score_digit_sequencer.sv
// Sequential double-dabble converter for the game score plus a time-multiplexed
// digit scanner that drives one shared digit decoder.
module score_digit_sequencer #(
  parameter int NUM_DIGITS = 4,
  parameter int SCORE_W    = 14,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_LZ   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SCORE_W-1:0]      score_in,
  input  logic                    score_load,
  output logic                    busy,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [3:0]              digit_num,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    digit_blank
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [31:0] MAX_VAL = 32'(10 ** NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  state_t             state;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   adjusted;
  logic [SCORE_W-1:0] bin;
  logic [SCORE_W-1:0] pend_val;
  logic               pending;
  logic [CNT_W-1:0]   bit_cnt;
  logic [PRE_W-1:0]   prescale;
  logic [IDX_W-1:0]   idx;
  logic               all_zero;

  // Scores beyond what the display can show saturate at all nines.
  function automatic logic [SCORE_W-1:0] clamp(input logic [SCORE_W-1:0] v);
    if (32'(v) > MAX_VAL) return SCORE_W'(MAX_VAL);
    return v;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
      assign adjusted[4*gi +: 4] = (scratch[4*gi +: 4] >= 4'd5) ?
                                   scratch[4*gi +: 4] + 4'd3 : scratch[4*gi +: 4];
    end
  endgenerate

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      scratch  <= '0;
      bin      <= '0;
      pend_val <= '0;
      pending  <= 1'b0;
      bit_cnt  <= '0;
      bcd_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (score_load) begin
            bin     <= clamp(score_in);
            scratch <= '0;
            bit_cnt <= '0;
            state   <= CONVERT;
          end
        end
        CONVERT: begin
          scratch <= {adjusted[BCD_W-2:0], bin[SCORE_W-1]};
          bin     <= {bin[SCORE_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
          if (score_load) begin
            pending  <= 1'b1;
            pend_val <= score_in;
          end
          if (bit_cnt == CNT_W'(SCORE_W - 1)) state <= COMMIT;
        end
        COMMIT: begin
          bcd_out <= scratch;
          // A load arriving on the commit cycle is the newest request, so it wins.
          if (score_load || pending) begin
            bin     <= clamp(score_load ? score_in : pend_val);
            scratch <= '0;
            bit_cnt <= '0;
            pending <= 1'b0;
            state   <= CONVERT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale <= '0;
      idx      <= '0;
    end else if (prescale == PRE_W'(SCAN_DIV - 1)) begin
      prescale <= '0;
      idx      <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  // Walk from the top digit down so all_zero means "this and every higher nibble is 0".
  always_comb begin
    digit_num   = 4'd0;
    digit_sel   = '0;
    digit_blank = 1'b0;
    all_zero    = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero && (bcd_out[4*i +: 4] == 4'd0);
      if (idx == IDX_W'(i)) begin
        digit_num    = bcd_out[4*i +: 4];
        digit_sel[i] = 1'b1;
        digit_blank  = (BLANK_LZ != 0) && (i != 0) && all_zero;
      end
    end
  end

endmodule

// File: tb/tb_score_digit_sequencer.sv
// Randomized and directed checks of score_digit_sequencer against a decimal-arithmetic
// model; two instances differ only in leading-zero blanking.
module tb_score_digit_sequencer;

  localparam int ND = 4;
  localparam int SW = 14;
  localparam int SD = 4;
  localparam int CONV = SW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          score_load = 1'b0;
  logic [SW-1:0] score_in = '0;

  logic          a_busy, b_busy;
  logic [15:0]   a_bcd, b_bcd;
  logic [3:0]    a_num, b_num;
  logic [ND-1:0] a_sel, b_sel;
  logic          a_blank, b_blank;

  int compared = 0;
  int mismatched = 0;
  int n_edges;
  logic [15:0] exp_bcd = '0;

  score_digit_sequencer #(.NUM_DIGITS(ND), .SCORE_W(SW), .SCAN_DIV(SD), .BLANK_LZ(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .score_in(score_in), .score_load(score_load),
    .busy(a_busy), .bcd_out(a_bcd), .digit_num(a_num), .digit_sel(a_sel),
    .digit_blank(a_blank));

  score_digit_sequencer #(.NUM_DIGITS(ND), .SCORE_W(SW), .SCAN_DIV(SD), .BLANK_LZ(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .score_in(score_in), .score_load(score_load),
    .busy(b_busy), .bcd_out(b_bcd), .digit_num(b_num), .digit_sel(b_sel),
    .digit_blank(b_blank));

  always #5 clk = ~clk;

  // Edges seen since reset release; the scan position follows from this alone.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n_edges <= 0;
    else        n_edges <= n_edges + 1;
  end

  function automatic logic [15:0] to_bcd(input int v);
    int c;
    logic [15:0] r;
    c = (v > 9999) ? 9999 : v;
    r = '0;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'((c / (10 ** i)) % 10);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_scan();
    int idx;
    logic [15:0] upper;
    idx   = (n_edges / SD) % ND;
    upper = exp_bcd >> (4 * idx);
    chk("digit_sel", 32'(a_sel), 32'(1 << idx));
    chk("digit_num", 32'(a_num), 32'(exp_bcd[4*idx +: 4]));
    chk("digit_blank_lz1", 32'(a_blank), 32'((idx > 0) && (upper == 16'h0)));
    chk("digit_blank_lz0", 32'(b_blank), 32'd0);
    chk("bcd_out_a", 32'(a_bcd), 32'(exp_bcd));
    chk("bcd_out_b", 32'(b_bcd), 32'(exp_bcd));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("busy_idle", 32'(a_busy), 32'd0);
      check_scan();
    end
  endtask

  // Load v0, then optional extra loads sampled at edges k+at1 / k+at2 (0 = none).
  task automatic run_load(input int v0, input int at1, input int v1, input int at2, input int v2);
    logic [15:0] old_bcd;
    int last;
    int total;
    old_bcd = exp_bcd;
    last  = (at2 > 0) ? v2 : ((at1 > 0) ? v1 : v0);
    total = (at1 > 0) ? 2 * CONV : CONV;
    score_in = SW'(v0);
    score_load = 1'b1;
    step();
    for (int j = 0; j <= total; j++) begin
      if (j < CONV)       exp_bcd = old_bcd;
      else if (j < total) exp_bcd = to_bcd(v0);
      else                exp_bcd = to_bcd(last);
      chk("busy", 32'(a_busy), 32'(j < total));
      chk("busy_b", 32'(b_busy), 32'(j < total));
      check_scan();
      score_load = ((at1 > 0) && (j + 1 == at1)) || ((at2 > 0) && (j + 1 == at2));
      score_in   = ((at2 > 0) && (j + 1 == at2)) ? SW'(v2) : SW'(v1);
      step();
    end
    score_load = 1'b0;
    check_scan();
    $display("load %0d (+%0d@%0d, +%0d@%0d) -> bcd_out=%h", v0, v1, at1, v2, at2, a_bcd);
  endtask

  initial begin
    int a1, a2;
    rst_n = 1'b0;
    step();
    step();
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_bcd", 32'(a_bcd), 32'd0);
    chk("rst_sel", 32'(a_sel), 32'd1);
    chk("rst_num", 32'(a_num), 32'd0);
    chk("rst_blank", 32'(a_blank), 32'd0);
    rst_n = 1'b1;
    idle(6);
    run_load(1234, 0, 0, 0, 0);
    idle(3);
    #1 rst_n = 1'b0;
    #1;
    exp_bcd = '0;
    chk("midscan_rst_sel", 32'(a_sel), 32'd1);
    chk("midscan_rst_num", 32'(a_num), 32'd0);
    chk("midscan_rst_busy", 32'(a_busy), 32'd0);
    chk("midscan_rst_bcd", 32'(a_bcd), 32'd0);
    step();
    rst_n = 1'b1;
    idle(4);

    run_load(1234, 0, 0, 0, 0);
    run_load(16383, 0, 0, 0, 0);
    run_load(0, 0, 0, 0, 0);
    idle(16);
    run_load(5678, 0, 0, 0, 0);
    idle(16);
    run_load(7, 0, 0, 0, 0);
    idle(16);
    run_load(42, 3, 99, 5, 77);
    idle(4);

    repeat (6) begin
      run_load(int'($urandom_range(0, 16383)), 0, 0, 0, 0);
      idle(int'($urandom_range(0, 5)));
    end
    repeat (4) begin
      a1 = int'($urandom_range(1, 13));
      a2 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(a1 + 1, 14)) : 0;
      run_load(int'($urandom_range(0, 16383)), a1, int'($urandom_range(0, 16383)),
               a2, int'($urandom_range(0, 16383)));
    end

    // Reset in the middle of a conversion discards it.
    score_in = SW'(500);
    score_load = 1'b1;
    step();
    score_load = 1'b0;
    repeat (4) step();
    #1 rst_n = 1'b0;
    #1;
    exp_bcd = '0;
    chk("convrst_busy", 32'(a_busy), 32'd0);
    chk("convrst_bcd", 32'(a_bcd), 32'd0);
    step();
    rst_n = 1'b1;
    idle(20);
    chk("convrst_stays_zero", 32'(a_bcd), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
